// File: rtl/eth_phy_10g_pkg.sv
// Shared constants and types for the 10G PHY TX path.
// The gearbox takes 66-bit blocks and emits 64-bit SERDES words.
package eth_phy_10g_pkg;

  // One encoded block is a 64-bit payload plus a 2-bit sync header.
  localparam int BLOCK_WIDTH = 66;
  localparam int WORD_WIDTH  = 64;
  localparam int HDR_BITS    = 2;

  // Sync header values. hdr[0] is the first bit sent on the line.
  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  // For every 32 blocks in, 33 words come out.
  localparam int GEARBOX_RATIO_IN  = 32;
  localparam int GEARBOX_RATIO_OUT = 33;

  // Smallest bit buffer that can hold the worst case: 62 leftover bits
  // plus one new block.
  localparam int GEARBOX_BUF_MIN = (WORD_WIDTH - HDR_BITS) + BLOCK_WIDTH;

  // Block in serial order. hdr sits in the low bits, so it is sent first
  // when the packed value goes out LSB first.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic [HDR_BITS-1:0]   hdr;
  } block_t;

  // Builds the serial block value from its two fields.
  function automatic block_t make_block(input logic [WORD_WIDTH-1:0] data,
                                        input logic [HDR_BITS-1:0]   hdr);
    block_t b;
    b.data = data;
    b.hdr  = hdr;
    return b;
  endfunction

endpackage

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 66b -> 64b TX gearbox. Incoming blocks are packed LSB first into a bit
// buffer at the current fill offset. A 64-bit word is taken from the bottom
// of the buffer whenever at least 64 bits are available. The input is
// stalled for one cycle in 33, when the buffer holds a full spare word.
module eth_phy_10g_tx_gearbox
  import eth_phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int BUF_WIDTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  tx_underflow,
  output logic [6:0]            fill_level
);

  // The fill count goes up to 64, so it needs 7 bits. Fill plus one block
  // can reach 128, so that sum needs 8 bits.
  localparam int CNT_W = 7;
  localparam int TOT_W = 8;

  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_WIDTH);
  localparam logic [TOT_W-1:0] WORD_TOT  = TOT_W'(WORD_WIDTH);
  localparam logic [TOT_W-1:0] BLOCK_TOT = TOT_W'(BLOCK_WIDTH);

  // State
  logic                  run_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BUF_WIDTH-1:0]  bits_q, bits_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  underflow_q, underflow_d;

  // Combinational helpers
  block_t                block;
  logic                  accept;
  logic                  emit;
  logic [TOT_W-1:0]      total;
  logic [BUF_WIDTH-1:0]  bits_ins;

  // Accept a new block only while there is room for 66 more bits, that is
  // while fill <= 62. Fill is always even, so "< 64" is the same test.
  assign in_ready = run_q & (cnt_q < WORD_CNT);
  assign accept   = in_valid & in_ready;
  assign block    = make_block(in_data, in_hdr);

  // Insert the accepted block at the fill offset, then decide whether a
  // word goes out this cycle. Bits above the fill offset are always zero,
  // so OR-ing the block in is the same as writing it.
  always_comb begin
    bits_ins    = bits_q;
    total       = {1'b0, cnt_q};
    bits_d      = bits_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    underflow_d = 1'b0;

    if (accept) begin
      bits_ins = bits_q | (BUF_WIDTH'(block) << cnt_q);
      total    = {1'b0, cnt_q} + BLOCK_TOT;
    end

    emit = (total >= WORD_TOT);

    if (emit) begin
      out_data_d  = bits_ins[DATA_WIDTH-1:0];
      out_valid_d = 1'b1;
      bits_d      = bits_ins >> DATA_WIDTH;
      cnt_d       = CNT_W'(total - WORD_TOT);
    end else begin
      // The output slot is starved. The buffered bits stay where they are,
      // so the line stream stays gap-free once blocks resume. Before the
      // first cycle of operation, no slot is owed, so no pulse is raised.
      underflow_d = run_q;
    end
  end

  // Register the run flag, the buffer, the fill count and the output.
  // An async reset discards any partially sent data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      cnt_q       <= '0;
      bits_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign tx_underflow = underflow_q;
  assign fill_level   = cnt_q;

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// Directed bench for the 66b->64b TX gearbox.
// A bit-level scoreboard follows every accepted block and every emitted word.
module tb_eth_phy_10g_tx_gearbox;
  import eth_phy_10g_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data = '0;
  logic [1:0]  in_hdr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        tx_underflow;
  logic [6:0]  fill_level;

  eth_phy_10g_tx_gearbox #(
    .DATA_WIDTH(64),
    .HDR_WIDTH (2),
    .BUF_WIDTH (128)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_hdr      (in_hdr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .tx_underflow(tx_underflow),
    .fill_level  (fill_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Serial bit scoreboard: bits pushed on accept, popped per output word.
  bit          sb[$];
  bit          mon_en = 1'b0;
  int          ov_run = 0;
  int          ov_max = 0;
  logic [65:0] mon_blk;
  logic [63:0] mon_word;

  // in_ready low statistics collected by send_blocks
  int ir_low_cnt = 0;
  int ir_last_low = 0;
  int ir_spacing_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs here reflect the previous posedge. Inputs here are the
  // values the next posedge will see.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        ov_run++;
        if (ov_run > ov_max) ov_max = ov_run;
        if (sb.size() < 64) begin
          chk("stream_underrun", 64'(sb.size()), 64'd64);
        end else begin
          mon_word = '0;
          for (int i = 0; i < 64; i++) mon_word[i] = sb.pop_front();
          chk("stream_word", out_data, mon_word);
        end
      end else begin
        ov_run = 0;
      end
      if (in_valid && in_ready) begin
        mon_blk = {in_data, in_hdr};
        for (int i = 0; i < 66; i++) sb.push_back(mon_blk[i]);
      end
    end
  end

  // Entered just after a posedge. Returns just after the posedge of run.
  task automatic do_reset(input bit check);
    mon_en   = 1'b0;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    if (check) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_underflow", 64'(tx_underflow), 64'd0);
      chk("rst_fill", 64'(fill_level), 64'd0);
    end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    if (check) chk("rel_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    if (check) chk("rel_ready_after_edge", 64'(in_ready), 64'd1);
    ov_run = 0;
    ov_max = 0;
    mon_en = 1'b1;
  endtask

  task automatic new_block();
    in_data = {$urandom, $urandom};
    in_hdr  = ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL;
  endtask

  // Presents n unique random blocks back to back, with in_valid held high.
  // Entered just after a posedge. Returns just after the last accepting
  // posedge, with in_valid low.
  task automatic send_blocks(input int n);
    int  sent;
    int  guard;
    bit  acc;
    sent  = 0;
    guard = 0;
    new_block();
    in_valid = 1'b1;
    while (sent < n && guard < 2 * n + 10) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) begin
        if (ir_low_cnt > 0 && (guard - ir_last_low) != 33) ir_spacing_bad++;
        ir_last_low = guard;
        ir_low_cnt++;
      end
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        sent++;
        if (sent < n) new_block();
      end
    end
    in_valid = 1'b0;
    if (sent < n) chk("send_timeout", 64'(sent), 64'(n));
  endtask

  typedef struct {
    logic [1:0]  hdr;
    logic [63:0] data;
    logic [63:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // Expected first word = {data[61:0], hdr}, worked out by hand.
    vecs[0] = '{2'b01, 64'h0123456789ABCDEF, 64'h048D159E26AF37BD};
    vecs[1] = '{2'b10, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE};
    vecs[2] = '{2'b01, 64'h0000000000000000, 64'h0000000000000001};
    vecs[3] = '{2'b10, 64'h8000000000000001, 64'h0000000000000006};
    vecs[4] = '{2'b01, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAA9};

    @(posedge clk);
    #1;
    do_reset(1'b1);

    // First-word vectors: one block, then a starved cycle
    for (int v = 0; v < 5; v++) begin
      do_reset(1'b0);
      in_hdr   = vecs[v].hdr;
      in_data  = vecs[v].data;
      in_valid = 1'b1;
      @(negedge clk);
      chk("vec_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("vec_word", out_data, vecs[v].exp_word);
      chk("vec_valid", 64'(out_valid), 64'd1);
      chk("vec_fill", 64'(fill_level), 64'd2);
      chk("vec_no_underflow", 64'(tx_underflow), 64'd0);
      @(negedge clk);
      chk("vec_idle_valid", 64'(out_valid), 64'd0);
      chk("vec_idle_underflow", 64'(tx_underflow), 64'd1);
      chk("vec_idle_fill", 64'(fill_level), 64'd2);
      @(posedge clk);
      #1;
    end

    // Continuous stream of 330 blocks
    do_reset(1'b0);
    ir_low_cnt = 0;
    ir_last_low = 0;
    ir_spacing_bad = 0;
    send_blocks(330);
    @(negedge clk);
    @(negedge clk);
    chk("cont_ready_lows", 64'(ir_low_cnt), 64'd10);
    chk("cont_ready_spacing", 64'(ir_spacing_bad), 64'd0);
    chk("cont_valid_run", 64'(ov_max), 64'd340);
    chk("cont_fill", 64'(fill_level), 64'd20);
    chk("cont_sb_left", 64'(sb.size()), 64'd20);
    @(posedge clk);
    #1;

    // Underflow at fill 10, then resume
    do_reset(1'b0);
    send_blocks(5);
    @(negedge clk);
    chk("uf_pre_valid", 64'(out_valid), 64'd1);
    chk("uf_pre_fill", 64'(fill_level), 64'd10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("uf_valid", 64'(out_valid), 64'd0);
      chk("uf_pulse", 64'(tx_underflow), 64'd1);
      chk("uf_fill", 64'(fill_level), 64'd10);
    end
    @(posedge clk);
    #1;
    send_blocks(40);
    repeat (3) @(negedge clk);
    chk("uf_post_fill", 64'(fill_level), 64'd26);
    chk("uf_post_sb", 64'(sb.size()), 64'd26);
    @(posedge clk);
    #1;

    // Backpressure: a block held through the in_ready=0 cycle
    do_reset(1'b0);
    send_blocks(31);
    ir_low_cnt = 0;
    ir_last_low = 0;
    send_blocks(2);
    repeat (2) @(negedge clk);
    chk("bp_one_stall", 64'(ir_low_cnt), 64'd1);
    chk("bp_fill", 64'(fill_level), 64'd2);
    chk("bp_sb", 64'(sb.size()), 64'd2);
    @(posedge clk);
    #1;

    // Reset at fill 40, then a fresh block lands at bit 0
    do_reset(1'b0);
    send_blocks(20);
    @(negedge clk);
    chk("mid_fill40", 64'(fill_level), 64'd40);
    @(posedge clk);
    #1;
    do_reset(1'b1);
    in_hdr   = SYNC_DATA;
    in_data  = 64'hFEDCBA9876543210;
    in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_word", out_data, 64'hFB72EA61D950C842);
    chk("mid_hdr", 64'(out_data[1:0]), 64'(SYNC_DATA));
    chk("mid_valid", 64'(out_valid), 64'd1);
    chk("mid_fill", 64'(fill_level), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
